// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for the RV32I core.
// A load return cannot be stalled, so it always owns the write port.
// An ALU result that collides with a return waits in a one-entry skid
// buffer and drains on the first cycle with no load return. While the
// buffer is full, alu_wb_ready is low and upstream must hold its result.
// A pending-load scoreboard feeds decode-stage hazard detection.
module wb_port_arbiter #(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_wb_valid,
  input  logic [RegAddrWidth-1:0] alu_wb_rd,
  input  logic [DataWidth-1:0]    alu_wb_data,
  output logic                    alu_wb_ready,
  input  logic                    ld_issue_valid,
  input  logic [RegAddrWidth-1:0] ld_issue_rd,
  input  logic                    ld_ret_valid,
  input  logic [RegAddrWidth-1:0] ld_ret_rd,
  input  logic [DataWidth-1:0]    ld_ret_data,
  input  logic [RegAddrWidth-1:0] rs1_addr,
  input  logic [RegAddrWidth-1:0] rs2_addr,
  input  logic [RegAddrWidth-1:0] dec_rd_addr,
  output logic                    load_hazard,
  output logic                    rf_we,
  output logic [RegAddrWidth-1:0] rf_waddr,
  output logic [DataWidth-1:0]    rf_wdata
);

  localparam int NumRegs = 1 << RegAddrWidth;

  // IDLE: skid empty, ALU may proceed. HOLD: skid full, ALU stalled.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [RegAddrWidth-1:0] r_skid_rd;
  logic [RegAddrWidth-1:0] w_skid_rd_nxt;
  logic [DataWidth-1:0]    r_skid_data;
  logic [DataWidth-1:0]    w_skid_data_nxt;

  logic                    w_win_valid;
  logic [RegAddrWidth-1:0] w_win_rd;
  logic [DataWidth-1:0]    w_win_data;

  logic [NumRegs-1:0]      r_pending;
  logic [NumRegs-1:0]      w_pending_nxt;

  // The ALU is only accepted while the skid buffer is empty.
  assign alu_wb_ready = (r_state == ST_IDLE);

  // Pick the port winner this cycle and decide what the skid buffer holds next.
  always_comb begin
    w_state_nxt     = r_state;
    w_skid_rd_nxt   = r_skid_rd;
    w_skid_data_nxt = r_skid_data;
    w_win_valid     = 1'b0;
    w_win_rd        = '0;
    w_win_data      = '0;
    case (r_state)
      ST_IDLE: begin
        if (ld_ret_valid) begin
          w_win_valid = 1'b1;
          w_win_rd    = ld_ret_rd;
          w_win_data  = ld_ret_data;
          if (alu_wb_valid) begin
            // Displaced ALU result is accepted into the skid buffer.
            w_skid_rd_nxt   = alu_wb_rd;
            w_skid_data_nxt = alu_wb_data;
            w_state_nxt     = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (alu_wb_valid) begin
          w_win_valid = 1'b1;
          w_win_rd    = alu_wb_rd;
          w_win_data  = alu_wb_data;
        end else begin
          w_win_valid = 1'b0;
        end
      end
      ST_HOLD: begin
        if (ld_ret_valid) begin
          w_win_valid = 1'b1;
          w_win_rd    = ld_ret_rd;
          w_win_data  = ld_ret_data;
        end else begin
          // Drain cycle: ready stays low so no new ALU result is taken.
          w_win_valid = 1'b1;
          w_win_rd    = r_skid_rd;
          w_win_data  = r_skid_data;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and skid buffer registers; reset discards any buffered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_skid_rd   <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_skid_rd   <= w_skid_rd_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

  // Registered write port; x0 writes are consumed but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (w_win_valid) begin
      rf_we    <= (w_win_rd != '0);
      rf_waddr <= w_win_rd;
      rf_wdata <= w_win_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Scoreboard update: clear on return, then set on issue so a newer load wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (ld_ret_valid) begin
      w_pending_nxt[ld_ret_rd] = 1'b0;
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
    if (ld_issue_valid) begin
      w_pending_nxt[ld_issue_rd] = 1'b1;
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Pending-load vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Hazard looks only at the registered vector; a same-cycle return is not bypassed.
  assign load_hazard = r_pending[rs1_addr] | r_pending[rs2_addr] | r_pending[dec_rd_addr];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed cases with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based reference model of the write-port and scoreboard rules.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_wb_valid = 1'b0;
  logic [4:0]  alu_wb_rd = 5'd0;
  logic [31:0] alu_wb_data = 32'd0;
  logic        alu_wb_ready;
  logic        ld_issue_valid = 1'b0;
  logic [4:0]  ld_issue_rd = 5'd0;
  logic        ld_ret_valid = 1'b0;
  logic [4:0]  ld_ret_rd = 5'd0;
  logic [31:0] ld_ret_data = 32'd0;
  logic [4:0]  rs1_addr = 5'd5;
  logic [4:0]  rs2_addr = 5'd5;
  logic [4:0]  dec_rd_addr = 5'd5;
  logic        load_hazard;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;
  bit en_cmp = 1'b0;

  wb_port_arbiter #(.DataWidth(32), .RegAddrWidth(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
    .ld_ret_valid(ld_ret_valid), .ld_ret_rd(ld_ret_rd), .ld_ret_data(ld_ret_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .dec_rd_addr(dec_rd_addr),
    .load_hazard(load_hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];         // ALU results accepted but not yet written
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic [31:0] m_pend = 32'd0;

  task automatic model_step();
    bit         acc;
    bit         have_w;
    ent_t       w;
    ent_t       a;
    if (!rst_n) begin
      m_q.delete();
      m_we   = 1'b0;
      m_addr = 5'd0;
      m_data = 32'd0;
      m_pend = 32'd0;
    end else begin
      acc    = alu_wb_valid && (m_q.size() == 0);
      a.rd   = alu_wb_rd;
      a.data = alu_wb_data;
      have_w = 1'b0;
      w      = '0;
      if (ld_ret_valid) begin
        have_w = 1'b1;
        w.rd   = ld_ret_rd;
        w.data = ld_ret_data;
        if (acc) m_q.push_back(a);
      end else if (m_q.size() > 0) begin
        have_w = 1'b1;
        w      = m_q.pop_front();
      end else if (acc) begin
        have_w = 1'b1;
        w      = a;
      end
      if (have_w) begin
        m_we   = (w.rd != 5'd0);
        m_addr = w.rd;
        m_data = w.data;
      end else begin
        m_we = 1'b0;
      end
      if (ld_ret_valid) m_pend[ld_ret_rd] = 1'b0;
      if (ld_issue_valid) m_pend[ld_issue_rd] = 1'b1;
      m_pend[0] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (en_cmp) begin
        chk("m_ready",  {31'd0, alu_wb_ready}, {31'd0, (m_q.size() == 0)});
        chk("m_rf_we",  {31'd0, rf_we}, {31'd0, m_we});
        chk("m_waddr",  {27'd0, rf_waddr}, {27'd0, m_addr});
        chk("m_wdata",  rf_wdata, m_data);
        chk("m_hazard", {31'd0, load_hazard},
            {31'd0, (m_pend[rs1_addr] | m_pend[rs2_addr] | m_pend[dec_rd_addr])});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_wb_valid   = 1'b0;
    ld_issue_valid = 1'b0;
    ld_ret_valid   = 1'b0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_wb_valid = 1'b1;
    alu_wb_rd    = rd;
    alu_wb_data  = d;
  endtask

  task automatic set_ret(input logic [4:0] rd, input logic [31:0] d);
    ld_ret_valid = 1'b1;
    ld_ret_rd    = rd;
    ld_ret_data  = d;
  endtask

  task automatic chk_wr(input string nm, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({nm, "_we"},   {31'd0, rf_we}, {31'd0, we});
    chk({nm, "_addr"}, {27'd0, rf_waddr}, {27'd0, a});
    chk({nm, "_data"}, rf_wdata, d);
  endtask

  initial begin
    bit acc_prev;

    // Reset state
    #1;
    chk_wr("rst", 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_ready",  {31'd0, alu_wb_ready}, 32'd1);
    chk("rst_hazard", {31'd0, load_hazard}, 32'd0);
    en_cmp = 1'b1;
    rs1_addr = 5'd0; rs2_addr = 5'd0; dec_rd_addr = 5'd0;

    // Single ALU write
    set_alu(5'd3, 32'h0000_00AA);
    step();
    idle_in();
    chk_wr("alu1", 1'b1, 5'd3, 32'h0000_00AA);
    chk("alu1_ready", {31'd0, alu_wb_ready}, 32'd1);
    step();
    chk("alu1_idle_we", {31'd0, rf_we}, 32'd0);
    chk("alu1_hold_addr", {27'd0, rf_waddr}, 32'd3);

    // Collision then drain
    set_alu(5'd4, 32'h1111); set_ret(5'd7, 32'h2222);
    step();
    idle_in();
    chk_wr("col_c1", 1'b1, 5'd7, 32'h2222);
    chk("col_c1_ready", {31'd0, alu_wb_ready}, 32'd0);
    step();
    chk_wr("col_c2", 1'b1, 5'd4, 32'h1111);
    chk("col_c2_ready", {31'd0, alu_wb_ready}, 32'd1);

    // Back-to-back returns in HOLD, with a new ALU result held upstream
    set_alu(5'd4, 32'h1111); set_ret(5'd7, 32'h2222);
    step();
    set_alu(5'd5, 32'h5555); set_ret(5'd8, 32'h8888);
    chk("b2b_r0", {31'd0, alu_wb_ready}, 32'd0);
    step();
    chk_wr("b2b_8", 1'b1, 5'd8, 32'h8888);
    chk("b2b_r1", {31'd0, alu_wb_ready}, 32'd0);
    set_ret(5'd9, 32'h9999);
    step();
    chk_wr("b2b_9", 1'b1, 5'd9, 32'h9999);
    chk("b2b_r2", {31'd0, alu_wb_ready}, 32'd0);
    ld_ret_valid = 1'b0;
    step();
    chk_wr("b2b_drain", 1'b1, 5'd4, 32'h1111);
    chk("b2b_r3", {31'd0, alu_wb_ready}, 32'd1);
    step();
    idle_in();
    chk_wr("b2b_held", 1'b1, 5'd5, 32'h5555);

    // Scoreboard
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd10; rs1_addr = 5'd10;
    #1;
    chk("sb_pre", {31'd0, load_hazard}, 32'd0);
    step();
    ld_issue_valid = 1'b0;
    chk("sb_set", {31'd0, load_hazard}, 32'd1);
    set_ret(5'd10, 32'h0000_00A0);
    #1;
    chk("sb_nobypass", {31'd0, load_hazard}, 32'd1);
    step();
    idle_in();
    #1;
    chk("sb_clr", {31'd0, load_hazard}, 32'd0);
    chk_wr("sb_ret", 1'b1, 5'd10, 32'h0000_00A0);
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd10; set_ret(5'd10, 32'h0000_00A1);
    step();
    idle_in();
    #1;
    chk("sb_setwins", {31'd0, load_hazard}, 32'd1);
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd11; rs1_addr = 5'd0; rs2_addr = 5'd11;
    step();
    idle_in();
    chk("sb_rs2", {31'd0, load_hazard}, 32'd1);
    rs2_addr = 5'd0; dec_rd_addr = 5'd11;
    #1;
    chk("sb_dec", {31'd0, load_hazard}, 32'd1);
    set_ret(5'd11, 32'h0B); step();
    set_ret(5'd10, 32'h0A); step();
    idle_in();
    #1;
    rs1_addr = 5'd10;
    #1;
    chk("sb_all_clr", {31'd0, load_hazard}, 32'd0);

    // x0 handling
    rs1_addr = 5'd0; dec_rd_addr = 5'd0;
    set_alu(5'd0, 32'hDEAD);
    step();
    idle_in();
    chk_wr("x0_alu", 1'b0, 5'd0, 32'hDEAD);
    chk("x0_ready", {31'd0, alu_wb_ready}, 32'd1);
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
    step();
    idle_in();
    #1;
    chk("x0_hazard", {31'd0, load_hazard}, 32'd0);

    // Reset mid-operation: skid full and a load pending
    set_alu(5'd6, 32'h66); set_ret(5'd12, 32'h1212);
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd13;
    step();
    idle_in();
    rs1_addr = 5'd13;
    #1;
    chk("mr_pre_hazard", {31'd0, load_hazard}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_we", {31'd0, rf_we}, 32'd0);
    chk("mr_ready", {31'd0, alu_wb_ready}, 32'd1);
    chk("mr_hazard", {31'd0, load_hazard}, 32'd0);
    step();
    rst_n = 1'b1;
    set_ret(5'd13, 32'h1313);
    step();
    idle_in();
    chk_wr("mr_late", 1'b1, 5'd13, 32'h1313);
    step();
    chk("mr_noskid", {31'd0, rf_we}, 32'd0);
    rs1_addr = 5'd0;

    // Randomized traffic; upstream holds an un-accepted ALU result
    acc_prev = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!alu_wb_valid || acc_prev) begin
        alu_wb_valid = ($urandom_range(0, 9) < 6);
        alu_wb_rd    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        alu_wb_data  = $urandom;
      end
      ld_ret_valid   = ($urandom_range(0, 9) < 4);
      ld_ret_rd      = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ld_ret_data    = $urandom;
      ld_issue_valid = ($urandom_range(0, 9) < 3);
      ld_issue_rd    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      rs1_addr       = 5'($urandom_range(0, 31));
      rs2_addr       = 5'($urandom_range(0, 7));
      dec_rd_addr    = 5'($urandom_range(0, 3));
      @(negedge clk);
      acc_prev = alu_wb_valid && alu_wb_ready;
      step();
    end
    idle_in();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
